// File: rtl/gf2_mul_sched.sv
// gf2_mul_sched: two-requester scheduler in front of a shared bit-serial
// carry-less (GF(2)) multiplier. One operand pair is accepted at a time,
// multiplied over W cycles and returned with the owning requester's id.
// Optional macro GF_REDUCE_EN: adds a W-1 cycle reduction pass modulo POLY,
// so res_data carries the GF(2^W) product in its low W bits.
module gf2_mul_sched #(
  parameter int unsigned W = 8
`ifdef GF_REDUCE_EN
  , parameter logic [W:0] POLY = 9'h11B
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [W-1:0]     req_a0,
  input  logic [W-1:0]     req_b0,
  input  logic [W-1:0]     req_a1,
  input  logic [W-1:0]     req_b1,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [2*W-2:0]   res_data,
  output logic             res_id,
  output logic             busy
);

  localparam int unsigned AW = 2 * W - 1;
  localparam int unsigned CW = $clog2(W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
`ifdef GF_REDUCE_EN
    , RED = 2'd3
`endif
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [AW-1:0]   acc, acc_nxt;
  logic [W-1:0]    op_a, op_b;
  logic            op_id;
  logic            rr;
  logic [1:0]      grant;
`ifdef GF_REDUCE_EN
  logic [AW-1:0]   acc_sh;
`endif

  // Grant only exists in IDLE; it is suppressed while reset is held.
  assign req_ready = rst_n ? grant : 2'b00;

  // Next-state, arbitration and one multiply/reduce step per cycle.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    acc_nxt   = acc;
    grant     = 2'b00;
`ifdef GF_REDUCE_EN
    acc_sh    = acc << cnt;
`endif
    case (state)
      IDLE: begin
        case (req_valid)
          2'b01:   grant = 2'b01;
          2'b10:   grant = 2'b10;
          2'b11:   grant = rr ? 2'b10 : 2'b01;
          default: grant = 2'b00;
        endcase
        if (grant != 2'b00) begin
          state_nxt = MUL;
          cnt_nxt   = '0;
          acc_nxt   = '0;
        end
      end
      MUL: begin
        if (op_b[cnt]) acc_nxt = acc ^ (AW'(op_a) << cnt);
        if (cnt == CW'(W - 1)) begin
          cnt_nxt = '0;
`ifdef GF_REDUCE_EN
          state_nxt = RED;
`else
          state_nxt = DONE;
`endif
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
`ifdef GF_REDUCE_EN
      RED: begin
        // Bit under test is acc[AW-1-cnt]; cancel it with POLY aligned to it.
        if (acc_sh[AW-1]) acc_nxt = acc ^ (AW'(POLY) << (CW'(W - 2) - cnt));
        if (cnt == CW'(W - 2)) begin
          cnt_nxt   = '0;
          state_nxt = DONE;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
`endif
      DONE: begin
        if (res_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, operand capture, round-robin pointer and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      acc       <= '0;
      op_a      <= '0;
      op_b      <= '0;
      op_id     <= 1'b0;
      rr        <= 1'b0;
      res_data  <= '0;
      res_id    <= 1'b0;
      res_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      acc       <= acc_nxt;
      busy      <= (state_nxt != IDLE);
      res_valid <= (state_nxt == DONE);
      if (grant != 2'b00) begin
        op_a  <= grant[1] ? req_a1 : req_a0;
        op_b  <= grant[1] ? req_b1 : req_b0;
        op_id <= grant[1];
        rr    <= ~grant[1];
      end
      if (state != DONE && state_nxt == DONE) begin
        res_data <= acc_nxt;
        res_id   <= op_id;
      end
    end
  end

endmodule
